// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - operation-state encodings and decode helpers for param_fifo
package fifo_pkg;

  typedef enum logic [2:0] {
    ST_INIT     = 3'b000,
    ST_WRITE    = 3'b001,
    ST_READ     = 3'b010,
    ST_RW       = 3'b011,
    ST_WR_RDERR = 3'b100,
    ST_WR_ERR   = 3'b101,
    ST_RD_ERR   = 3'b110,
    ST_NO_OP    = 3'b111
  } fifo_state_e;

  typedef struct packed {
    logic wr_ack;
    logic wr_err;
    logic rd_ack;
    logic rd_err;
  } fifo_hs_t;

  // Full with a simultaneous read is still a legal RW: the read frees the slot.
  function automatic fifo_state_e next_state(input logic wr, input logic rd,
                                             input logic full, input logic empty);
    if (wr && rd) return empty ? ST_WR_RDERR : ST_RW;
    if (wr)       return full  ? ST_WR_ERR   : ST_WRITE;
    if (rd)       return empty ? ST_RD_ERR   : ST_READ;
    return ST_NO_OP;
  endfunction

  function automatic logic state_writes(input fifo_state_e s);
    return (s == ST_WRITE) || (s == ST_RW) || (s == ST_WR_RDERR);
  endfunction

  function automatic logic state_reads(input fifo_state_e s);
    return (s == ST_READ) || (s == ST_RW);
  endfunction

  function automatic fifo_hs_t decode_hs(input fifo_state_e s);
    fifo_hs_t hs;
    hs = '0;
    case (s)
      ST_WRITE:    hs.wr_ack = 1'b1;
      ST_READ:     hs.rd_ack = 1'b1;
      ST_RW:       begin hs.wr_ack = 1'b1; hs.rd_ack = 1'b1; end
      ST_WR_RDERR: begin hs.wr_ack = 1'b1; hs.rd_err = 1'b1; end
      ST_WR_ERR:   hs.wr_err = 1'b1;
      ST_RD_ERR:   hs.rd_err = 1'b1;
      default:     hs = '0;
    endcase
    return hs;
  endfunction

endpackage

// File: rtl/fifo_mem.sv
// rtl/fifo_mem.sv - WIDTH x DEPTH register file, sync write port, registered read port
module fifo_mem #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)   rd_data_q <= '0;
    else if (rd_en) rd_data_q <= mem_q[rd_addr];
  end

  assign rd_data = rd_data_q;

endmodule

// File: rtl/param_fifo.sv
// rtl/param_fifo.sv - parametrised sync FIFO with handshake FSM; FIFO_ALMOST_FLAGS_EN enables almost flags
module param_fifo
  import fifo_pkg::*;
#(
  parameter int unsigned WIDTH     = 32,
  parameter int unsigned DEPTH     = 8,
  parameter int unsigned AF_MARGIN = 1,
  parameter int unsigned AE_MARGIN = 1
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   wr_en,
  input  logic                   rd_en,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic [$clog2(DEPTH):0] data_count,
  output logic                   full,
  output logic                   empty,
  output logic                   almost_full,
  output logic                   almost_empty,
  output logic                   wr_ack,
  output logic                   wr_err,
  output logic                   rd_ack,
  output logic                   rd_err
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  if ((DEPTH < 2) || ((DEPTH & (DEPTH - 1)) != 0) ||
      (AF_MARGIN > DEPTH) || (AE_MARGIN > DEPTH)) begin : g_bad_params
    $error("param_fifo: DEPTH must be a power of two >= 2 and margins <= DEPTH");
  end

  fifo_state_e   state_q, state_d;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_wr, do_rd;
  fifo_hs_t      hs;

  // The decision for this edge is the state about to be registered.
  always_comb begin
    state_d  = next_state(wr_en, rd_en, full, empty);
    do_wr    = state_writes(state_d);
    do_rd    = state_reads(state_d);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_rd) rd_ptr_d = rd_ptr_q + AW'(1);
    if (do_wr && !do_rd)      count_d = count_q + CW'(1);
    else if (do_rd && !do_wr) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_INIT;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_en   (do_wr),
    .wr_addr (wr_ptr_q),
    .wr_data (din),
    .rd_en   (do_rd),
    .rd_addr (rd_ptr_q),
    .rd_data (dout)
  );

  assign hs         = decode_hs(state_q);
  assign wr_ack     = hs.wr_ack;
  assign wr_err     = hs.wr_err;
  assign rd_ack     = hs.rd_ack;
  assign rd_err     = hs.rd_err;

  assign data_count = count_q;
  assign full       = (count_q == CW'(DEPTH));
  assign empty      = (count_q == '0);

`ifdef FIFO_ALMOST_FLAGS_EN
  assign almost_full  = (count_q >= CW'(DEPTH - AF_MARGIN));
  assign almost_empty = (count_q <= CW'(AE_MARGIN));
`else
  assign almost_full  = 1'b0;
  assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_param_fifo.sv
// tb/tb_param_fifo.sv - self-checking bench for param_fifo
module tb_param_fifo;

  localparam int WIDTH = 32;
  localparam int DEPTH = 8;
  localparam int AFM   = 1;
  localparam int AEM   = 1;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             wr_en = 1'b0;
  logic             rd_en = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic [WIDTH-1:0] dout;
  logic [3:0]       data_count;
  logic             full, empty, almost_full, almost_empty;
  logic             wr_ack, wr_err, rd_ack, rd_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  param_fifo #(
    .WIDTH(WIDTH), .DEPTH(DEPTH), .AF_MARGIN(AFM), .AE_MARGIN(AEM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .rd_en(rd_en), .din(din),
    .dout(dout), .data_count(data_count), .full(full), .empty(empty),
    .almost_full(almost_full), .almost_empty(almost_empty),
    .wr_ack(wr_ack), .wr_err(wr_err), .rd_ack(rd_ack), .rd_err(rd_err)
  );

  // Reference model: a plain queue of stored words plus the last word read.
  logic [31:0] mq[$];
  logic [31:0] m_dout;
  logic [3:0]  m_hs;   // {wr_ack, wr_err, rd_ack, rd_err}

  typedef struct {
    logic        wr;
    logic        rd;
    logic [31:0] d;
    int          cnt;
    logic [31:0] dout;
    logic [3:0]  hs;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic exp_af(input int cnt);
`ifdef FIFO_ALMOST_FLAGS_EN
    return cnt >= DEPTH - AFM;
`else
    return (cnt < 0);
`endif
  endfunction

  function automatic logic exp_ae(input int cnt);
`ifdef FIFO_ALMOST_FLAGS_EN
    return cnt <= AEM;
`else
    return (cnt < 0);
`endif
  endfunction

  task automatic check_flags(input string tag, input int cnt);
    check({tag, "_count"}, 32'(data_count), 32'(cnt));
    check({tag, "_full"},  32'(full),  32'(cnt == DEPTH));
    check({tag, "_empty"}, 32'(empty), 32'(cnt == 0));
    check({tag, "_afull"}, 32'(almost_full),  32'(exp_af(cnt)));
    check({tag, "_aempty"}, 32'(almost_empty), 32'(exp_ae(cnt)));
  endtask

  task automatic check_model(input string tag);
    check_flags(tag, mq.size());
    check({tag, "_dout"}, dout, m_dout);
    check({tag, "_hs"}, 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'(m_hs));
  endtask

  task automatic model_step(input logic wr, input logic rd, input logic [31:0] d);
    bit was_full, was_empty;
    was_full  = (mq.size() == DEPTH);
    was_empty = (mq.size() == 0);
    m_hs = 4'b0000;
    if (wr && rd) begin
      if (was_empty) begin
        mq.push_back(d);
        m_hs = 4'b1001;
      end else begin
        m_dout = mq.pop_front();
        mq.push_back(d);
        m_hs = 4'b1010;
      end
    end else if (wr) begin
      if (was_full) m_hs = 4'b0100;
      else begin mq.push_back(d); m_hs = 4'b1000; end
    end else if (rd) begin
      if (was_empty) m_hs = 4'b0001;
      else begin m_dout = mq.pop_front(); m_hs = 4'b0010; end
    end
  endtask

  task automatic apply(input logic wr, input logic rd, input logic [31:0] d);
    wr_en = wr;
    rd_en = rd;
    din   = d;
    model_step(wr, rd, d);
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset(input string tag);
    reset_n = 1'b0;
    wr_en = 1'b0;
    rd_en = 1'b0;
    mq.delete();
    m_dout = '0;
    m_hs = '0;
    repeat (2) @(posedge clk);
    #1;
    check_model(tag);
    @(negedge clk);
    reset_n = 1'b1;
  endtask

  initial begin
    m_dout = '0;
    m_hs = '0;

    // Reset, then one idle edge leaves INIT for NO_OP with no handshake.
    do_reset("rst");
    apply(1'b0, 1'b0, '0);
    check_model("idle");

    // Directed table: fill, overflow, drain, underflow, simultaneous on empty.
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back('{1'b1, 1'b0, 32'((i + 1) * 'h11), i + 1, 32'h0, 4'b1000});
    vecs.push_back('{1'b1, 1'b0, 32'h99, 8, 32'h0, 4'b0100});
    for (int i = 0; i < DEPTH; i++)
      vecs.push_back('{1'b0, 1'b1, 32'h0, 7 - i, 32'((i + 1) * 'h11), 4'b0010});
    vecs.push_back('{1'b0, 1'b1, 32'h0, 0, 32'h88, 4'b0001});
    vecs.push_back('{1'b1, 1'b1, 32'hA5, 1, 32'h88, 4'b1001});
    vecs.push_back('{1'b0, 1'b0, 32'h0, 1, 32'h88, 4'b0000});
    vecs.push_back('{1'b0, 1'b1, 32'h0, 0, 32'hA5, 4'b0010});

    foreach (vecs[k]) begin
      apply(vecs[k].wr, vecs[k].rd, vecs[k].d);
      check_flags($sformatf("vec%0d", k), vecs[k].cnt);
      check($sformatf("vec%0d_dout", k), dout, vecs[k].dout);
      check($sformatf("vec%0d_hs", k), 32'({wr_ack, wr_err, rd_ack, rd_err}), 32'(vecs[k].hs));
    end

    // RW while full, three laps round the pointers.
    do_reset("rst_rwfull");
    for (int i = 0; i < DEPTH; i++) apply(1'b1, 1'b0, 32'($urandom));
    check_model("fill");
    for (int i = 0; i < 3 * DEPTH; i++) begin
      apply(1'b1, 1'b1, 32'($urandom));
      check_model("rw_full");
    end

    // RW at half level, three laps.
    for (int i = 0; i < DEPTH / 2; i++) apply(1'b0, 1'b1, '0);
    check_model("half");
    for (int i = 0; i < 3 * DEPTH; i++) begin
      apply(1'b1, 1'b1, 32'($urandom));
      check_model("rw_half");
    end

    // Reset asserted mid-cycle during a write burst takes effect immediately.
    do_reset("rst_burst");
    for (int i = 0; i < 5; i++) apply(1'b1, 1'b0, 32'($urandom));
    check_model("burst5");
    wr_en = 1'b1;
    din   = 32'hDEAD_BEEF;
    #2;
    reset_n = 1'b0;
    wr_en = 1'b0;
    mq.delete();
    m_dout = '0;
    m_hs = '0;
    #1;
    check_model("async_rst");
    @(negedge clk);
    reset_n = 1'b1;
    apply(1'b0, 1'b0, '0);
    check_model("post_rst");

    // Randomised traffic in phases biased toward filling, draining and balanced.
    for (int ph = 0; ph < 6; ph++) begin
      int wp;
      int rp;
      wp = (ph % 3 == 0) ? 80 : (ph % 3 == 1) ? 20 : 50;
      rp = (ph % 3 == 0) ? 25 : (ph % 3 == 1) ? 80 : 50;
      for (int i = 0; i < 300; i++) begin
        apply(1'($urandom_range(0, 99) < wp), 1'($urandom_range(0, 99) < rp), 32'($urandom));
        check_model($sformatf("rand%0d", ph));
      end
    end

    wr_en = 1'b0;
    rd_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
